// File: rtl/mem_cmd_responder.sv
// mem_cmd_responder
//   Memory-side responder for control-bus command words {addr, 2'b00, dest, src, op}.
//   Reads (op 00 key / op 01 text, src==MEM_ID) fetch bytes from memory one at a time
//   and stream them out. Writes (op 10 digest, dest==MEM_ID) take bytes from the rx
//   stream and write them to memory. ack_out = {1'b1, MEM_ID} pulses for one cycle
//   when the transfer is done.
// Ports
//   clk, rst_n                      clock, async active-low reset
//   cmd_valid, cmd_data, cmd_ready  command strobe / word / idle indication
//   mem_req, mem_we, mem_addr,      byte-wide memory port with request/grant
//   mem_wdata, mem_gnt, mem_rdata,  handshake and read-data valid
//   mem_rvalid
//   tx_data, tx_dest, tx_valid,     outgoing read-data stream
//   tx_ready
//   rx_data, rx_valid, rx_ready     incoming write-data stream
//   ack_out                         completion pulse
//   range_err                       only when RESP_RANGE_CHK_EN is defined
// Configuration macro: RESP_RANGE_CHK_EN
//   Defined: a command whose span runs past the top of the address space does no
//   traffic, goes straight to ACK and pulses range_err with the ack.
//   Undefined: addresses wrap modulo 2^ADDRW.
module mem_cmd_responder #(
  parameter int         ADDRW        = 24,
  parameter logic [1:0] MEM_ID       = 2'b00,
  parameter int         KEY_BYTES    = 32,
  parameter int         TEXT_BYTES   = 64,
  parameter int         DIGEST_BYTES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [ADDRW+7:0] cmd_data,
  output logic             cmd_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic [ADDRW-1:0] mem_addr,
  output logic [7:0]       mem_wdata,
  input  logic             mem_gnt,
  input  logic [7:0]       mem_rdata,
  input  logic             mem_rvalid,
  output logic [7:0]       tx_data,
  output logic [1:0]       tx_dest,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [2:0]       ack_out
`ifdef RESP_RANGE_CHK_EN
  ,
  output logic             range_err
`endif
);

  localparam int MAX_RD = (KEY_BYTES > TEXT_BYTES) ? KEY_BYTES : TEXT_BYTES;
  localparam int MAXLEN = (MAX_RD > DIGEST_BYTES) ? MAX_RD : DIGEST_BYTES;
  localparam int CW     = $clog2(MAXLEN) + 1;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, RD_SEND, WR_RECV, WR_REQ, ACK} state_t;

  state_t           state;
  logic [ADDRW-1:0] addr_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    len_q;
  logic [7:0]       byte_q;

  logic [ADDRW-1:0] cmd_addr;
  logic [1:0]       cmd_dest, cmd_src, cmd_op;
  logic [CW-1:0]    cmd_len;
  logic             is_rd, is_wr, last;
  logic             unused_bits;

  assign cmd_addr    = cmd_data[ADDRW+7:8];
  assign cmd_dest    = cmd_data[5:4];
  assign cmd_src     = cmd_data[3:2];
  assign cmd_op      = cmd_data[1:0];
  assign unused_bits = ^cmd_data[7:6];

  assign is_rd = (cmd_op == 2'b00 || cmd_op == 2'b01) && (cmd_src == MEM_ID);
  assign is_wr = (cmd_op == 2'b10) && (cmd_dest == MEM_ID);
  assign last  = (cnt_q == len_q - CW'(1));

  always_comb begin
    cmd_len = CW'(KEY_BYTES);
    case (cmd_op)
      2'b01:   cmd_len = CW'(TEXT_BYTES);
      2'b10:   cmd_len = CW'(DIGEST_BYTES);
      default: cmd_len = CW'(KEY_BYTES);
    endcase
  end

`ifdef RESP_RANGE_CHK_EN
  // One extra bit catches spans that run past the top of the address space.
  logic [ADDRW:0] end_addr;
  logic           range_bad;
  assign end_addr  = {1'b0, cmd_addr} + {{(ADDRW+1-CW){1'b0}}, cmd_len} - (ADDRW+1)'(1);
  assign range_bad = end_addr[ADDRW];
`endif

  assign mem_addr  = addr_q;
  assign mem_wdata = byte_q;
  assign tx_data   = byte_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      byte_q    <= '0;
      tx_dest   <= '0;
      cmd_ready <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      tx_valid  <= 1'b0;
      rx_ready  <= 1'b0;
      ack_out   <= 3'b000;
`ifdef RESP_RANGE_CHK_EN
      range_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && (is_rd || is_wr)) begin
            addr_q    <= cmd_addr;
            tx_dest   <= cmd_dest;
            cnt_q     <= '0;
            len_q     <= cmd_len;
            cmd_ready <= 1'b0;
`ifdef RESP_RANGE_CHK_EN
            if (range_bad) begin
              state     <= ACK;
              ack_out   <= {1'b1, MEM_ID};
              range_err <= 1'b1;
            end else
`endif
            if (is_rd) begin
              state   <= RD_REQ;
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
            end else begin
              state    <= WR_RECV;
              rx_ready <= 1'b1;
            end
          end
        end
        RD_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem_rvalid) begin
            byte_q   <= mem_rdata;
            tx_valid <= 1'b1;
            state    <= RD_SEND;
          end
        end
        RD_SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            addr_q   <= addr_q + ADDRW'(1);
            cnt_q    <= cnt_q + CW'(1);
            if (last) begin
              state   <= ACK;
              ack_out <= {1'b1, MEM_ID};
            end else begin
              state   <= RD_REQ;
              mem_req <= 1'b1;
            end
          end
        end
        WR_RECV: begin
          if (rx_valid) begin
            byte_q   <= rx_data;
            rx_ready <= 1'b0;
            mem_req  <= 1'b1;
            mem_we   <= 1'b1;
            state    <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            addr_q  <= addr_q + ADDRW'(1);
            cnt_q   <= cnt_q + CW'(1);
            if (last) begin
              state   <= ACK;
              ack_out <= {1'b1, MEM_ID};
            end else begin
              state    <= WR_RECV;
              rx_ready <= 1'b1;
            end
          end
        end
        ACK: begin
          ack_out   <= 3'b000;
          cmd_ready <= 1'b1;
          state     <= IDLE;
`ifdef RESP_RANGE_CHK_EN
          range_err <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
